// File: rtl/reg_writeback_if.sv
// Result handshakes, register-file write port and forwarding
// lookup bundled for the write-back sequencer.
interface reg_writeback_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        regWr;
  logic [4:0]  rW;
  logic [31:0] busW;
  logic [4:0]  rA;
  logic [4:0]  rB;
  logic        fwdA_hit;
  logic        fwdB_hit;
  logic [31:0] fwdA_data;
  logic [31:0] fwdB_data;
  logic        empty;

  modport slave (
    input  alu_valid,
    input  alu_rd,
    input  alu_data,
    input  ld_valid,
    input  ld_rd,
    input  ld_data,
    input  rA,
    input  rB,
    output alu_ready,
    output ld_ready,
    output regWr,
    output rW,
    output busW,
    output fwdA_hit,
    output fwdB_hit,
    output fwdA_data,
    output fwdB_data,
    output empty
  );

  modport master (
    output alu_valid,
    output alu_rd,
    output alu_data,
    output ld_valid,
    output ld_rd,
    output ld_data,
    output rA,
    output rB,
    input  alu_ready,
    input  ld_ready,
    input  regWr,
    input  rW,
    input  busW,
    input  fwdA_hit,
    input  fwdB_hit,
    input  fwdA_data,
    input  fwdB_data,
    input  empty
  );
endinterface

// File: rtl/reg_writeback.sv
// Write-back sequencer: in-order FIFO of ALU/load results that
// retires one register write per cycle and forwards pending data.
module reg_writeback #(
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  reg_writeback_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          reg_wr_q, reg_wr_d;
  logic [4:0]    rw_q, rw_d;
  logic [31:0]   busw_q, busw_d;

  logic [4:0]    mem_rd_q   [DEPTH];
  logic [4:0]    mem_rd_d   [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [31:0]   mem_data_d [DEPTH];

  logic [CW-1:0] free;
  logic          alu_fire;
  logic          ld_fire;
  logic          alu_push;
  logic          ld_push;
  logic          pop;
  logic [AW-1:0] ld_slot;

  logic          fa_hit, fb_hit;
  logic [31:0]   fa_data, fb_data;
  logic [AW-1:0] idx;

  assign free     = FULL - count_q;
  assign pop      = (count_q != '0);

  assign bus.alu_ready = (free != '0);
  assign bus.ld_ready  = (free >= CW'(2)) ||
                         ((free == CW'(1)) && !bus.alu_valid);

  assign alu_fire = bus.alu_valid && bus.alu_ready;
  assign ld_fire  = bus.ld_valid && bus.ld_ready;
  assign alu_push = alu_fire && (bus.alu_rd != 5'd0);
  assign ld_push  = ld_fire && (bus.ld_rd != 5'd0);
  assign ld_slot  = tail_q + AW'(alu_push);

  assign bus.regWr = reg_wr_q;
  assign bus.rW    = rw_q;
  assign bus.busW  = busw_q;
  assign bus.empty = (count_q == '0) && !reg_wr_q;

  assign bus.fwdA_hit  = fa_hit;
  assign bus.fwdB_hit  = fb_hit;
  assign bus.fwdA_data = fa_data;
  assign bus.fwdB_data = fb_data;

  // Next FIFO state: ALU enqueues ahead of load, head pops to the port.
  always_comb begin
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    if (alu_push) begin
      mem_rd_d[tail_q]   = bus.alu_rd;
      mem_data_d[tail_q] = bus.alu_data;
    end
    if (ld_push) begin
      mem_rd_d[ld_slot]   = bus.ld_rd;
      mem_data_d[ld_slot] = bus.ld_data;
    end
    tail_d  = tail_q + AW'(alu_push) + AW'(ld_push);
    head_d  = head_q + AW'(pop);
    count_d = count_q + CW'(alu_push) + CW'(ld_push) - CW'(pop);
    reg_wr_d = pop;
    rw_d     = rw_q;
    busw_d   = busw_q;
    if (pop) begin
      rw_d   = mem_rd_q[head_q];
      busw_d = mem_data_q[head_q];
    end
  end

  // Control state and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      reg_wr_q <= 1'b0;
      rw_q     <= '0;
      busw_q   <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      reg_wr_q <= reg_wr_d;
      rw_q     <= rw_d;
      busw_q   <= busw_d;
    end
  end

  // Entry storage; stale contents are masked by count.
  always_ff @(posedge clk) begin
    mem_rd_q   <= mem_rd_d;
    mem_data_q <= mem_data_d;
  end

  // Forwarding: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fa_hit  = 1'b0;
    fb_hit  = 1'b0;
    fa_data = '0;
    fb_data = '0;
    idx     = '0;
    if (reg_wr_q) begin
      if ((bus.rA != 5'd0) && (rw_q == bus.rA)) begin
        fa_hit  = 1'b1;
        fa_data = busw_q;
      end
      if ((bus.rB != 5'd0) && (rw_q == bus.rB)) begin
        fb_hit  = 1'b1;
        fb_data = busw_q;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if (CW'(i) < count_q) begin
        if ((bus.rA != 5'd0) && (mem_rd_q[idx] == bus.rA)) begin
          fa_hit  = 1'b1;
          fa_data = mem_data_q[idx];
        end
        if ((bus.rB != 5'd0) && (mem_rd_q[idx] == bus.rB)) begin
          fb_hit  = 1'b1;
          fb_data = mem_data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a queue scoreboard of
// expected register writes and forwarding lookups.
module tb_reg_writeback;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  int errors;
  int checks;

  logic [36:0] fifo_m [$];
  bit          exp_wr;
  logic [4:0]  exp_rw;
  logic [31:0] exp_busw;

  reg_writeback_if bus ();

  reg_writeback #(
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void fwd_model(input logic [4:0] r,
                                    output bit hit,
                                    output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (r != 5'd0) begin
      if (exp_wr && exp_rw == r) begin
        hit = 1'b1;
        d   = exp_busw;
      end
      foreach (fifo_m[i]) begin
        if (fifo_m[i][36:32] == r) begin
          hit = 1'b1;
          d   = fifo_m[i][31:0];
        end
      end
    end
  endfunction

  task automatic cycle(input bit av, input logic [4:0] ard,
                       input logic [31:0] ad,
                       input bit lv, input logic [4:0] lrd,
                       input logic [31:0] ldd,
                       input logic [4:0] ra, input logic [4:0] rb);
    int free;
    bit er_a, er_l, ha, hb, acc_a, acc_l;
    logic [31:0] da, db;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_rd     = lrd;
    bus.ld_data   = ldd;
    bus.rA        = ra;
    bus.rB        = rb;
    #1;
    free = DEPTH - fifo_m.size();
    er_a = (free >= 1);
    er_l = (free >= 2) || (free == 1 && !av);
    chk("alu_ready", 32'(bus.alu_ready), 32'(er_a));
    chk("ld_ready", 32'(bus.ld_ready), 32'(er_l));
    fwd_model(ra, ha, da);
    fwd_model(rb, hb, db);
    chk("fwdA_hit", 32'(bus.fwdA_hit), 32'(ha));
    chk("fwdA_data", bus.fwdA_data, da);
    chk("fwdB_hit", 32'(bus.fwdB_hit), 32'(hb));
    chk("fwdB_data", bus.fwdB_data, db);
    acc_a = av && er_a;
    acc_l = lv && er_l;
    @(posedge clk);
    if (fifo_m.size() > 0) begin
      exp_wr = 1'b1;
      {exp_rw, exp_busw} = fifo_m.pop_front();
    end else begin
      exp_wr = 1'b0;
    end
    if (acc_a && ard != 5'd0) fifo_m.push_back({ard, ad});
    if (acc_l && lrd != 5'd0) fifo_m.push_back({lrd, ldd});
    #1;
    chk("regWr", 32'(bus.regWr), 32'(exp_wr));
    chk("rW", 32'(bus.rW), 32'(exp_rw));
    chk("busW", bus.busW, exp_busw);
    chk("empty", 32'(bus.empty),
        32'(fifo_m.size() == 0 && !exp_wr));
  endtask

  task automatic idle(input int n, input logic [4:0] ra,
                      input logic [4:0] rb);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, rb);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    bus.alu_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.alu_rd    = 5'd0;
    bus.ld_rd     = 5'd0;
    bus.alu_data  = '0;
    bus.ld_data   = '0;
    bus.rA        = 5'd5;
    bus.rB        = 5'd7;
    repeat (n) @(posedge clk);
    #1;
    fifo_m.delete();
    exp_wr   = 1'b0;
    exp_rw   = '0;
    exp_busw = '0;
    chk("rst_regWr", 32'(bus.regWr), 32'd0);
    chk("rst_rW", 32'(bus.rW), 32'd0);
    chk("rst_busW", bus.busW, 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("rst_ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("rst_fwdA_hit", 32'(bus.fwdA_hit), 32'd0);
    chk("rst_fwdB_hit", 32'(bus.fwdB_hit), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_wr = 1'b0;
    exp_rw = '0;
    exp_busw = '0;

    // reset then idle
    do_reset(2);
    idle(2, 5'd5, 5'd0);

    // single ALU write, watched through forwarding on rA=5
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    chk("single_rW", 32'(fifo_m.size()), 32'd1);
    idle(3, 5'd5, 5'd6);
    chk("single_busW", bus.busW, 32'hDEADBEEF);

    // dual issue: ALU first, then load
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd3, 5'd4);
    idle(1, 5'd3, 5'd4);
    chk("dual_first_rW", 32'(bus.rW), 32'd3);
    idle(1, 5'd3, 5'd4);
    chk("dual_second_rW", 32'(bus.rW), 32'd4);
    idle(2, 5'd3, 5'd4);

    // youngest wins on repeated destination
    cycle(1'b1, 5'd7, 32'hA, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    cycle(1'b1, 5'd7, 32'hB, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    chk("youngest_data", bus.fwdA_data, 32'hB);
    idle(4, 5'd7, 5'd7);

    // dual stream, r0 discards, ld-only slots, pointer wrap
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, (i % 5 == 2) ? 5'd0 : 5'(i + 1),
            32'h1000 + 32'(i),
            1'b1, 5'(i + 13), 32'h2000 + 32'(i),
            5'((i * 3) % 20), 5'd0);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 5'd1, 32'h0, 1'b1, 5'(i + 1), 32'h3000 + 32'(i),
            5'(i + 1), 5'd14);
    end
    idle(6, 5'd0, 5'd24);

    // reset with pending writes drops them
    cycle(1'b1, 5'd5, 32'h55, 1'b1, 5'd7, 32'h77, 5'd5, 5'd7);
    cycle(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 5'd5, 5'd7);
    chk("pending_count", 32'(fifo_m.size()), 32'd3);
    do_reset(1);
    idle(4, 5'd9, 5'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
